// File: rtl/ecc_read_scheduler.sv
// Two-port read scheduler sharing one memory read path and an external SEC
// hamming decoder/encoder; scrubs corrected words and counts corrections.
module ecc_read_scheduler #(
  parameter int ADDR_W    = 8,
  parameter int WRITEBACK = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_valid,
  input  logic [ADDR_W-1:0] a_req_addr,
  output logic              a_req_ready,
  output logic              a_rsp_valid,
  output logic [7:0]        a_rsp_data,
  output logic              a_rsp_err,
  input  logic              b_req_valid,
  input  logic [ADDR_W-1:0] b_req_addr,
  output logic              b_req_ready,
  output logic              b_rsp_valid,
  output logic [7:0]        b_rsp_data,
  output logic              b_rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata,
  output logic [11:0]       dec_code,
  input  logic [7:0]        dec_data,
  input  logic              dec_err,
  output logic [7:0]        enc_data,
  input  logic [11:0]       enc_code,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD, CAP, DEC, RSP, WB} state_t;

  localparam logic WB_EN = (WRITEBACK != 0);

  state_t            state, state_next;
  logic [11:0]       code_q;
  logic [7:0]        data_q;
  logic              err_q;
  logic              owner_q;     // 0 = port A, 1 = port B
  logic [ADDR_W-1:0] addr_q;
  logic              last_grant;  // 0 = port A, 1 = port B
  logic [CNT_W-1:0]  count_q;
  logic              grant_a, grant_b, accept;

  // Round-robin: on contention the port that did not win last time goes first.
  assign grant_a = a_req_valid && (!b_req_valid || last_grant);
  assign grant_b = b_req_valid && (!a_req_valid || !last_grant);

  // Gated by rst_n so no handshake can be seen during reset.
  assign a_req_ready = (state == IDLE) && rst_n && grant_a;
  assign b_req_ready = (state == IDLE) && rst_n && grant_b;
  assign accept      = a_req_ready || b_req_ready;

  assign dec_code  = code_q;
  assign enc_data  = data_q;
  assign err_count = count_q;
  assign busy      = (state != IDLE);

  always_comb begin
    state_next  = state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    a_rsp_valid = 1'b0;
    a_rsp_data  = '0;
    a_rsp_err   = 1'b0;
    b_rsp_valid = 1'b0;
    b_rsp_data  = '0;
    b_rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = RD;
      end
      RD: begin
        mem_en     = 1'b1;
        mem_addr   = addr_q;
        state_next = CAP;
      end
      CAP: state_next = DEC;
      DEC: state_next = RSP;
      RSP: begin
        if (!owner_q) begin
          a_rsp_valid = 1'b1;
          a_rsp_data  = data_q;
          a_rsp_err   = err_q;
        end else begin
          b_rsp_valid = 1'b1;
          b_rsp_data  = data_q;
          b_rsp_err   = err_q;
        end
        // Parity-only corrections are scrubbed too; the data is unchanged.
        state_next = (err_q && WB_EN) ? WB : IDLE;
      end
      WB: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = addr_q;
        mem_wdata  = enc_code;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      code_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      last_grant <= 1'b1;
      count_q    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q     <= b_req_ready ? b_req_addr : a_req_addr;
        owner_q    <= b_req_ready;
        last_grant <= b_req_ready;
      end
      if (state == CAP) code_q <= mem_rdata;
      if (state == DEC) begin
        data_q <= dec_data;
        err_q  <= dec_err;
      end
      // Clear wins over a same-cycle increment; the count sticks at all-ones.
      if (clr_count)
        count_q <= '0;
      else if (state == DEC && dec_err && count_q != {CNT_W{1'b1}})
        count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
